// File: rtl/hsst_rst_pkg.sv
// Shared definitions for the HSST/PCIe reset-request handshake.
//
// Contents:
//   rst_state_e        - 2-bit state encoding of the request generator
//   FarStretchCycles   - reset stretch applied by the far-side synchronizer/stretcher
//   AckTimeoutDefault  - default acknowledge timeout; covers the far-side stretch plus
//                        synchronizer latency with margin
//   state_drives_rstn  - whether a state releases the far-side reset (rstn_req=1)
//   state_is_busy      - whether a state belongs to an in-flight sequence
package hsst_rst_pkg;

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StWaitAck = 2'd1,
    StDone    = 2'd2,
    StFail    = 2'd3
  } rst_state_e;

  localparam logic [15:0] FarStretchCycles  = 16'hC001;
  localparam logic [15:0] AckTimeoutDefault = 16'hFFFF;

  // rstn_req is high only while the far side is allowed out of reset.
  function automatic logic state_drives_rstn(rst_state_e s);
    return (s == StWaitAck) || (s == StDone);
  endfunction

  function automatic logic state_is_busy(rst_state_e s);
    return (s == StAssert) || (s == StWaitAck);
  endfunction

endpackage

// File: rtl/hsst_rst_ack_sync.sv
// Two-flop synchronizer for a single asynchronous status bit.
//
// Ports:
//   clk      - destination clock
//   rstn_in  - asynchronous active-low reset; both stages clear to 0
//   d        - asynchronous input
//   q        - synchronized output, two clk cycles of latency
//
// Generic enough to reuse for any slow async status input into the clk domain.
module hsst_rst_ack_sync (
  input  logic clk,
  input  logic rstn_in,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/hsst_rst_req_gen.sv
// Initiator side of the HSST/PCIe reset handshake.
//
// Drives an active-low reset request to the far-side reset synchronizer/stretcher,
// holds it low for ASSERT_CYCLES, then waits for the far side's "reset released"
// acknowledge. A missing acknowledge times out after ACK_TIMEOUT cycles and the
// request is retried up to MAX_RETRY times before a sticky FAIL state is entered.
// A power-up sequence starts automatically when rstn_in is released.
//
// Ports:
//   clk           - single clock domain
//   rstn_in       - asynchronous active-low reset
//   req_sw        - software/CSR reset request, synchronous
//   req_lol       - loss-of-lock level request; holds reset asserted while high
//   ack_in        - far-side rstn_out, asynchronous; synchronized internally
//   rstn_req      - active-low reset request to the far side
//   busy          - sequence in progress (ASSERT or WAIT_ACK)
//   done          - acknowledge received (DONE)
//   fail          - retries exhausted (FAIL), sticky until req_sw
//   retry_cnt     - timeouts seen in the current sequence
//   rst_stat_cnt  - completed-sequence count
//
// Build option: IPS2L_PCIE_RST_STAT_EN enables the 8-bit saturating completed-sequence
// counter on rst_stat_cnt; when undefined rst_stat_cnt is tied to zero.
module hsst_rst_req_gen
  import hsst_rst_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned ASSERT_CYCLES = 255,
  parameter int unsigned ACK_TIMEOUT   = AckTimeoutDefault,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned RETRY_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rstn_in,
  input  logic                   req_sw,
  input  logic                   req_lol,
  input  logic                   ack_in,
  output logic                   rstn_req,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [RETRY_WIDTH-1:0] retry_cnt,
  output logic [7:0]             rst_stat_cnt
);

  // Terminal counts; the counter never runs past these, so it never wraps.
  localparam logic [CNT_WIDTH-1:0]   AssertLast  = CNT_WIDTH'(ASSERT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   TimeoutLast = CNT_WIDTH'(ACK_TIMEOUT - 1);
  localparam logic [RETRY_WIDTH-1:0] RetryMax    = RETRY_WIDTH'(MAX_RETRY);

  logic                   ack_s;
  logic                   any_req;
  rst_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [RETRY_WIDTH-1:0] retry_q, retry_d;

  hsst_rst_ack_sync u_ack_sync (
    .clk     (clk),
    .rstn_in (rstn_in),
    .d       (ack_in),
    .q       (ack_s)
  );

  // Simultaneous software and loss-of-lock requests collapse into one request.
  assign any_req = req_sw | req_lol;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    unique case (state_q)
      StAssert: begin
        // Either request (re)starts the assert window, so rstn_req stays low for
        // ASSERT_CYCLES after the last requesting cycle.
        if (any_req) begin
          cnt_d = '0;
        end else if (cnt_q == AssertLast) begin
          state_d = StWaitAck;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      StWaitAck: begin
        // A fresh request restarts the sequence ahead of anything else; the
        // acknowledge beats a timeout landing on the same cycle.
        if (any_req) begin
          state_d = StAssert;
          cnt_d   = '0;
        end else if (ack_s) begin
          state_d = StDone;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d = '0;
          if (retry_q < RetryMax) begin
            state_d = StAssert;
            retry_d = retry_q + RETRY_WIDTH'(1);
          end else begin
            state_d = StFail;
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      StDone: begin
        // Far side dropping its acknowledge means it went back into reset; resync.
        if (any_req || !ack_s) begin
          state_d = StAssert;
          cnt_d   = '0;
          retry_d = '0;
        end
      end

      StFail: begin
        // Loss of lock cannot clear a failure; only software can.
        if (req_sw) begin
          state_d = StAssert;
          cnt_d   = '0;
          retry_d = '0;
        end
      end

      default: begin
        state_d = StFail;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs decode state_d so they change on the same edge as state_q.
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q  <= StAssert;
      cnt_q    <= '0;
      retry_q  <= '0;
      rstn_req <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      rstn_req <= state_drives_rstn(state_d);
      busy     <= state_is_busy(state_d);
      done     <= (state_d == StDone);
      fail     <= (state_d == StFail);
    end
  end

  assign retry_cnt = retry_q;

`ifdef IPS2L_PCIE_RST_STAT_EN
  logic [7:0] stat_q;

  // Counts successful handshakes; saturates and is cleared only by rstn_in.
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      stat_q <= 8'h00;
    end else if ((state_q == StWaitAck) && (state_d == StDone) && (stat_q != 8'hFF)) begin
      stat_q <= stat_q + 8'd1;
    end
  end

  assign rst_stat_cnt = stat_q;
`else
  assign rst_stat_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_hsst_rst_req_gen.sv
// Bench for hsst_rst_req_gen: directed scenarios followed by random stimulus, with a
// per-cycle scoreboard fed by a behavioural model of the reset handshake.
module tb_hsst_rst_req_gen;

  localparam int unsigned A  = 4;   // assert width
  localparam int unsigned T  = 20;  // acknowledge timeout
  localparam int unsigned MR = 2;   // retries

  logic       clk     = 1'b0;
  logic       rstn_in = 1'b1;
  logic       req_sw  = 1'b0;
  logic       req_lol = 1'b0;
  logic       ack_in  = 1'b0;
  logic       rstn_req, busy, done, fail;
  logic [1:0] retry_cnt;
  logic [7:0] rst_stat_cnt;

  hsst_rst_req_gen #(
    .CNT_WIDTH     (16),
    .ASSERT_CYCLES (A),
    .ACK_TIMEOUT   (T),
    .MAX_RETRY     (MR),
    .RETRY_WIDTH   (2)
  ) dut (
    .clk          (clk),
    .rstn_in      (rstn_in),
    .req_sw       (req_sw),
    .req_lol      (req_lol),
    .ack_in       (ack_in),
    .rstn_req     (rstn_req),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .rst_stat_cnt (rst_stat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rstn_req;
    logic       busy;
    logic       done;
    logic       fail;
    logic [1:0] retry;
    logic [7:0] stat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  // Behavioural model: phase of the handshake plus "low cycles still owed" and
  // "cycles spent waiting", and the two most recent ack_in samples.
  typedef enum {M_LOW, M_WAIT, M_UP, M_FAILED} mph_e;
  mph_e m_ph;
  int   m_left, m_elapsed, m_retry, m_stat;
  logic m_s1, m_s2;

  task automatic model_reset();
    m_ph = M_LOW; m_left = A; m_elapsed = 0; m_retry = 0; m_stat = 0;
    m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  task automatic model_edge();
    logic ack_seen;
    logic want;
    ack_seen = m_s2;
    want     = req_sw | req_lol;
    case (m_ph)
      M_LOW: begin
        if (want) m_left = A;
        else if (m_left == 1) begin m_ph = M_WAIT; m_elapsed = 0; end
        else m_left--;
      end
      M_WAIT: begin
        m_elapsed++;
        if (want) begin m_ph = M_LOW; m_left = A; end
        else if (ack_seen) begin
          m_ph = M_UP;
          if (m_stat < 255) m_stat++;
        end else if (m_elapsed == T) begin
          if (m_retry < MR) begin m_retry++; m_ph = M_LOW; m_left = A; end
          else m_ph = M_FAILED;
        end
      end
      M_UP: begin
        if (want || !ack_seen) begin m_ph = M_LOW; m_left = A; m_retry = 0; end
      end
      default: begin
        if (req_sw) begin m_ph = M_LOW; m_left = A; m_retry = 0; end
      end
    endcase
    m_s2 = m_s1;
    m_s1 = ack_in;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.rstn_req = (m_ph == M_WAIT) || (m_ph == M_UP);
    e.busy     = (m_ph == M_LOW) || (m_ph == M_WAIT);
    e.done     = (m_ph == M_UP);
    e.fail     = (m_ph == M_FAILED);
    e.retry    = 2'(m_retry);
`ifdef IPS2L_PCIE_RST_STAT_EN
    e.stat     = 8'(m_stat);
`else
    e.stat     = 8'h00;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic bound_expired(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  // One clock: model follows the edge, expectation queued, inputs may change after.
  task automatic step();
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic pulse_sw();
    req_sw = 1'b1;
    step();
    req_sw = 1'b0;
  endtask

  task automatic run_until(input mph_e ph, input int budget, input string name);
    int k;
    k = 0;
    while (m_ph != ph && k < budget) begin
      step();
      k++;
    end
    if (m_ph != ph) bound_expired(name);
  endtask

  // Scoreboard monitor, half a cycle after each edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if ({rstn_req, busy, done, fail, retry_cnt, rst_stat_cnt} !== mon_e) begin
        n_bad++;
        $display("FAIL scoreboard @%0t: got rstn_req=%b busy=%b done=%b fail=%b retry=%0d stat=%0d, expected rstn_req=%b busy=%b done=%b fail=%b retry=%0d stat=%0d",
                 $time, rstn_req, busy, done, fail, retry_cnt, rst_stat_cnt,
                 mon_e.rstn_req, mon_e.busy, mon_e.done, mon_e.fail, mon_e.retry, mon_e.stat);
      end
    end
  end

  initial begin
    int k;
    int lol_hold;
    lol_hold = 0;
    model_reset();

    // Reset values
    #1 rstn_in = 1'b0;
    #2;
    chk("reset_rstn_req", 8'(rstn_req), 8'd0);
    chk("reset_busy", 8'(busy), 8'd1);
    chk("reset_done", 8'(done), 8'd0);
    chk("reset_fail", 8'(fail), 8'd0);
    chk("reset_retry", 8'(retry_cnt), 8'd0);
    chk("reset_stat", rst_stat_cnt, 8'd0);
    #9 rstn_in = 1'b1;

    // Power-up: rstn_req low for exactly A edges, then acknowledge
    k = 0;
    do begin step(); k++; end while (rstn_req !== 1'b1 && k < 20);
    chk("powerup_low_edges", 8'(k), 8'(A));
    ack_in = 1'b1;
    run_until(M_UP, 20, "powerup_done");
    chk("powerup_done", 8'(done), 8'd1);
    chk("powerup_retry", 8'(retry_cnt), 8'd0);

    // Loss of lock in DONE: held 10 cycles, then A more low cycles
    repeat (2) step();
    req_lol = 1'b1;
    step();
    chk("lol_rstn_low_next", 8'(rstn_req), 8'd0);
    repeat (9) step();
    req_lol = 1'b0;
    k = 0;
    while (rstn_req !== 1'b1 && k < 30) begin step(); k++; end
    chk("lol_release_edges", 8'(k), 8'(A));
    run_until(M_UP, 20, "lol_redone");

    // Far side drops acknowledge: rstn_req low 3 edges later
    repeat (2) step();
    ack_in = 1'b0;
    k = 0;
    while (rstn_req !== 1'b0 && k < 10) begin step(); k++; end
    chk("ackdrop_edges", 8'(k), 8'd3);
    chk("ackdrop_retry", 8'(retry_cnt), 8'd0);

    // No acknowledge: retries exhaust into sticky FAIL
    run_until(M_FAILED, 200, "noack_fail");
    chk("noack_fail", 8'(fail), 8'd1);
    chk("noack_rstn_req", 8'(rstn_req), 8'd0);
    chk("noack_retry", 8'(retry_cnt), 8'(MR));
    req_lol = 1'b1;
    repeat (3) step();
    req_lol = 1'b0;
    chk("fail_ignores_lol", 8'(fail), 8'd1);
    pulse_sw();
    chk("sw_clears_fail", 8'(fail), 8'd0);
    chk("sw_clears_retry", 8'(retry_cnt), 8'd0);
    chk("sw_restarts_busy", 8'(busy), 8'd1);

    // Acknowledge lands on the timeout cycle of the second attempt
    k = 0;
    while (!(m_ph == M_WAIT && m_retry == 1 && m_elapsed == T - 3) && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) bound_expired("collide_setup");
    ack_in = 1'b1;
    repeat (3) step();
    chk("collide_done", 8'(done), 8'd1);
    chk("collide_retry", 8'(retry_cnt), 8'd1);
    chk("collide_fail", 8'(fail), 8'd0);

    // 300 successful sequences for the completion counter
    for (int i = 0; i < 300; i++) begin
      pulse_sw();
      run_until(M_UP, 30, "stat_seq");
    end
    step();
`ifdef IPS2L_PCIE_RST_STAT_EN
    chk("stat_saturated", rst_stat_cnt, 8'hFF);
`else
    chk("stat_absent", rst_stat_cnt, 8'h00);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      req_sw = ($urandom_range(0, 39) == 0);
      if (lol_hold > 0) lol_hold--;
      else if ($urandom_range(0, 59) == 0) lol_hold = $urandom_range(1, 12);
      req_lol = (lol_hold > 0);
      if ($urandom_range(0, 29) == 0) ack_in = ~ack_in;
      step();
    end
    req_sw  = 1'b0;
    req_lol = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
